// File: rtl/bus_decoder_n.sv
// bus_decoder_n: routes one CPU data access to one of NUM_REGIONS slaves.
// The top SEL_BITS address bits select the slave. An access is rejected at
// once if it is illegal. A slave that stays silent for TIMEOUT cycles also
// ends the access with an error.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   data_address/read_en/write_en  CPU request, held until data_ready
//   data_write_value/size          CPU request payload
//   data_read_value/ready/error    registered one-cycle response
//   slave_address/write_value      shared registered slave payload
//   slave_data_size                shared registered slave payload
//   slave_read_en/write_en         one-hot per-region strobes
//   slave_read_value/ready         per-region slave response
module bus_decoder_n #(
    parameter int NUM_REGIONS = 3,
    parameter int SEL_BITS    = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [31:0]               data_address,
    input  logic                      data_read_en,
    input  logic                      data_write_en,
    input  logic [31:0]               data_write_value,
    input  logic [2:0]                data_size,
    output logic [31:0]               data_read_value,
    output logic                      data_ready,
    output logic                      data_error,
    output logic [31:0]               slave_address,
    output logic [31:0]               slave_write_value,
    output logic [2:0]                slave_data_size,
    output logic [NUM_REGIONS-1:0]    slave_read_en,
    output logic [NUM_REGIONS-1:0]    slave_write_en,
    input  logic [32*NUM_REGIONS-1:0] slave_read_value,
    input  logic [NUM_REGIONS-1:0]    slave_ready
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    state_e                   state_q;
    logic [7:0]               wait_q;
    logic [SEL_BITS-1:0]      region_q;
    logic                     write_q;
    logic [31:0]              rdata_q;
    logic                     ready_q;
    logic                     error_q;
    logic [31:0]              saddr_q;
    logic [31:0]              swdata_q;
    logic [2:0]               ssize_q;
    logic [NUM_REGIONS-1:0]   srd_en_q;
    logic [NUM_REGIONS-1:0]   swr_en_q;

    logic                     req;
    logic                     bad_d;
    logic [SEL_BITS-1:0]      region_d;
    logic [NUM_REGIONS-1:0]   onehot_d;
    logic                     sel_ready;
    logic [31:0]              sel_rdata;

    assign req      = data_read_en | data_write_en;
    assign region_d = data_address[31 -: SEL_BITS];

    always_comb begin
        bad_d = 1'b0;
        if (data_read_en && data_write_en)
            bad_d = 1'b1;
        if (data_size > 3'd2)
            bad_d = 1'b1;
        if (data_size == 3'd1 && data_address[0])
            bad_d = 1'b1;
        if (data_size == 3'd2 && data_address[1:0] != 2'b00)
            bad_d = 1'b1;
        if ({{(32-SEL_BITS){1'b0}}, region_d} >= 32'(NUM_REGIONS))
            bad_d = 1'b1;
    end

    always_comb begin
        onehot_d = '0;
        for (int i = 0; i < NUM_REGIONS; i++)
            onehot_d[i] = (32'(i) == {{(32-SEL_BITS){1'b0}}, region_d});
    end

    // Only the captured region's ready/data is ever looked at.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (32'(i) == {{(32-SEL_BITS){1'b0}}, region_q}) begin
                sel_ready = slave_ready[i];
                sel_rdata = slave_read_value[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            region_q <= '0;
            write_q  <= 1'b0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            error_q  <= 1'b0;
            saddr_q  <= '0;
            swdata_q <= '0;
            ssize_q  <= '0;
            srd_en_q <= '0;
            swr_en_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    error_q <= 1'b0;
                    if (req) begin
                        saddr_q  <= data_address;
                        swdata_q <= data_write_value;
                        ssize_q  <= data_size;
                        region_q <= region_d;
                        write_q  <= data_write_en;
                        wait_q   <= '0;
                        if (bad_d) begin
                            state_q <= RESP;
                            ready_q <= 1'b1;
                            error_q <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            state_q <= ACCESS;
                            if (data_write_en)
                                swr_en_q <= onehot_d;
                            else
                                srd_en_q <= onehot_d;
                        end
                    end
                end
                ACCESS: begin
                    // Ready wins over timeout in the final wait cycle.
                    if (sel_ready) begin
                        state_q  <= RESP;
                        ready_q  <= 1'b1;
                        error_q  <= 1'b0;
                        rdata_q  <= write_q ? 32'd0 : sel_rdata;
                        srd_en_q <= '0;
                        swr_en_q <= '0;
                    end else if (wait_q == 8'(TIMEOUT - 1)) begin
                        state_q  <= RESP;
                        ready_q  <= 1'b1;
                        error_q  <= 1'b1;
                        rdata_q  <= '0;
                        srd_en_q <= '0;
                        swr_en_q <= '0;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    error_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_read_value   = rdata_q;
    assign data_ready        = ready_q;
    assign data_error        = error_q;
    assign slave_address     = saddr_q;
    assign slave_write_value = swdata_q;
    assign slave_data_size   = ssize_q;
    assign slave_read_en     = srd_en_q;
    assign slave_write_en    = swr_en_q;

endmodule

// File: doc/bus_decoder_n.md
BUS_DECODER_N -- requirements
Module: bus_decoder_n

Interface
REQ-001 SHALL have parameter NUM_REGIONS, default 3; number of mapped slave regions (1..2**SEL_BITS).
REQ-002 SHALL have parameter SEL_BITS, default 2; region index = data_address[31 -: SEL_BITS].
REQ-003 SHALL have parameter TIMEOUT, default 16; the maximum number of ACCESS cycles allowed without slave_ready (range 2..255).
REQ-004 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port: rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port: data_address  in  32  CPU byte address.
REQ-007 SHALL have port: data_read_en  in  1  read request, held until data_ready.
REQ-008 SHALL have port: data_write_en  in  1  write request, held until data_ready.
REQ-009 SHALL have port: data_write_value  in  32  write data.
REQ-010 SHALL have port: data_size  in  3  0=byte, 1=half, 2=word; 3..7 illegal.
REQ-011 SHALL have port: data_read_value  out  32  registered read data, valid while data_ready=1.
REQ-012 SHALL have port: data_ready  out  1  one-cycle completion pulse.
REQ-013 SHALL have port: data_error  out  1  high with data_ready when the access failed.
REQ-014 SHALL have ports: slave_address out 32, slave_write_value out 32, slave_data_size out 3; all registered and shared by every slave.
REQ-015 SHALL have ports: slave_read_en out NUM_REGIONS, slave_write_en out NUM_REGIONS; one-hot or zero.
REQ-016 SHALL have ports: slave_read_value in 32*NUM_REGIONS (region i at bits [32i+31:32i]), slave_ready in NUM_REGIONS.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-018 In IDLE, the block SHALL capture address, write value, size, direction and region on any cycle with data_read_en or data_write_en high.
REQ-019 A captured request SHALL be rejected (IDLE->RESP, error=1, no slave enable) when any of the following holds: both read_en and write_en are high; data_size>2; size=1 with address[0]=1; size=2 with address[1:0]!=0; region index >= NUM_REGIONS.
REQ-020 Otherwise IDLE->ACCESS; in ACCESS only bit [region] of slave_read_en or slave_write_en SHALL be high, with slave_address/value/size stable.
REQ-021 ACCESS SHALL sample slave_ready[region] each cycle; when it is high, data_read_value SHALL latch slave_read_value[region] (reads only; writes return 0), and the FSM SHALL go ACCESS->RESP with error=0.
REQ-022 A wait counter SHALL clear on entry to ACCESS and increment each cycle without ready.
REQ-023 When the wait counter reaches TIMEOUT-1 without ready, ACCESS->RESP with error=1 and data_read_value=0; ready arriving in that same final cycle SHALL take priority (no error).
REQ-024 Slave enables SHALL drop in the cycle the FSM leaves ACCESS.
REQ-025 slave_ready bits of non-selected regions SHALL be ignored.
REQ-026 RESP SHALL last exactly one cycle, with data_ready=1 and data_error per REQ-019/021/023, then go to IDLE.
REQ-027 In RESP, new requests SHALL be ignored; the CPU drops its enables on data_ready, and the earliest next capture is in the following IDLE cycle.
REQ-028 Minimum latency SHALL be: request cycle N -> enable N+1 -> ready at N+1 -> data_ready N+2; rejected request: data_ready N+1.
REQ-029 Changes to inputs after capture SHALL NOT affect the in-flight access.

Reset
REQ-030 rst_n low SHALL immediately (asynchronously) force state IDLE, wait counter 0, all slave enables 0, data_ready 0, data_error 0, data_read_value 0, slave_address/value 0, slave_data_size 0.
REQ-031 Reset asserted mid-ACCESS SHALL abort the access without a data_ready pulse; after release, the first rising edge SHALL be treated as IDLE.

Verification
REQ-032 Read 0x40000010, size 2, slave_ready[1] asserted in the first ACCESS cycle with value 0xDEADBEEF -> slave_read_en=3'b010 for 1 cycle; data_ready 2 cycles after request; data_read_value=0xDEADBEEF; error=0.
REQ-033 Write 0x00000004, size 0, value 0xA5; slave 0 ready after 3 wait cycles -> slave_write_en=3'b001 for 4 cycles, slave_write_value=0xA5, data_ready with error=0.
REQ-034 Read 0xC0000000 (region 3 unmapped) -> no slave enable, data_ready+data_error next cycle; read 0x00000002 size 2 -> same error.
REQ-035 Read 0x80000000, slave 2 never ready -> enable high for 16 cycles, then data_ready, error=1, data_read_value=0; a second run with ready in cycle 16 -> error=0.
REQ-036 Request with both enables high, and a request with data_size=5 -> each yields immediate error; rst_n pulsed low mid-ACCESS -> all outputs 0 at once, no data_ready.
